retain_bus_arbiter: RTL

- Shares one WIDTH-bit bus between NREQ requesters using round-robin arbitration with a bounded ownership hold.
- Emulates charge-retaining (trireg-style) net behaviour in synthesizable logic:
  - When no requester drives, the bus keeps its last driven value.
  - After DECAY_CYCLES undriven cycles, the bus decays to DECAY_VALUE.
- Sits between producer blocks and any consumer that previously relied on a retained net.

---
 rtl/retain_bus_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 39 +++
 rtl/retain_bus_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/retain_bus_pkg.sv
// Shared types and helpers for the retaining bus arbiter.
// The bus status state and the default sizing live here.
package retain_bus_pkg;

  typedef enum logic [1:0] {
    DECAYED = 2'd0,
    DRIVE   = 2'd1,
    RETAIN  = 2'd2
  } bus_state_e;

  localparam int DEF_NREQ  = 3;
  localparam int DEF_WIDTH = 8;
  localparam int MAX_NREQ  = 8;

  // Returns the index of the set bit. Zero input maps to index 0.
  function automatic int onehot_to_idx(input logic [MAX_NREQ-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick with an owner-keep override.
// The search begins at 'start' and wraps modulo NREQ.
module rr_arbiter
  import retain_bus_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  input  logic [IW-1:0]   owner,
  input  logic            hold_keep,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    win   = '0;
    found = 1'b0;
    cand  = '0;
    if (hold_keep) begin
      win[owner] = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        cand = IW'((int'(start) + k) % NREQ);
        if (!found && req[cand]) begin
          win[cand] = 1'b1;
          found     = 1'b1;
        end
      end
    end
  end

  assign win_idx = IW'(onehot_to_idx(MAX_NREQ'(win)));

endmodule

// File: rtl/retain_bus_arbiter.sv
// Round-robin shared bus that retains its last driven value while idle and
// decays to a fixed value after a configurable number of undriven cycles.
module retain_bus_arbiter
  import retain_bus_pkg::*;
#(
  parameter int              NREQ         = DEF_NREQ,
  parameter int              WIDTH        = DEF_WIDTH,
  parameter int              HOLD_MAX     = 4,
  parameter int              DECAY_CYCLES = 16,
  parameter logic [WIDTH-1:0] DECAY_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic [WIDTH-1:0]        bus_data,
  output logic                    bus_driven,
  output logic                    bus_retained,
  output logic                    bus_decayed
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam int DW = (DECAY_CYCLES > 0) ? $clog2(DECAY_CYCLES + 1) : 1;

  bus_state_e      state;
  logic [IW-1:0]   ptr;
  logic [HW-1:0]   hold_cnt;
  logic [DW-1:0]   decay_cnt;

  logic [NREQ-1:0] own_mask;
  logic            others;
  logic            hold_keep;
  logic            hold_room;
  logic [NREQ-1:0] win;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   next_ptr;
  logic [WIDTH-1:0] sel_data;
  logic            decay_due;

  always_comb begin
    own_mask        = '0;
    own_mask[owner] = 1'b1;
  end

  assign others    = |(req & ~own_mask);
  assign hold_room = (int'(hold_cnt) < HOLD_MAX - 1);
  // Keeping only applies to a live grant; RETAIN/DECAYED always arbitrate fresh.
  assign hold_keep = (state == DRIVE) && req[owner] && (hold_room || !others);
  assign decay_due = (DECAY_CYCLES != 0) && (int'(decay_cnt) >= DECAY_CYCLES);

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req       (req),
    .start     (ptr),
    .owner     (owner),
    .hold_keep (hold_keep),
    .win       (win),
    .win_idx   (win_idx)
  );

  assign next_ptr = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + IW'(1);

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DECAYED;
      grant        <= '0;
      owner        <= '0;
      bus_data     <= DECAY_VALUE;
      bus_driven   <= 1'b0;
      bus_retained <= 1'b0;
      bus_decayed  <= 1'b1;
      ptr          <= '0;
      hold_cnt     <= '0;
      decay_cnt    <= '0;
    end else if (|req) begin
      // Any request beats a pending decay on the same edge.
      state        <= DRIVE;
      grant        <= win;
      owner        <= win_idx;
      bus_data     <= sel_data;
      bus_driven   <= 1'b1;
      bus_retained <= 1'b0;
      bus_decayed  <= 1'b0;
      ptr          <= next_ptr;
      decay_cnt    <= '0;
      if (hold_keep) begin
        if (hold_room) hold_cnt <= hold_cnt + HW'(1);
      end else begin
        hold_cnt <= '0;
      end
    end else begin
      case (state)
        DRIVE: begin
          state        <= RETAIN;
          grant        <= '0;
          bus_driven   <= 1'b0;
          bus_retained <= 1'b1;
          bus_decayed  <= 1'b0;
          decay_cnt    <= DW'(1);
        end
        RETAIN: begin
          if (decay_due) begin
            state        <= DECAYED;
            bus_data     <= DECAY_VALUE;
            bus_retained <= 1'b0;
            bus_decayed  <= 1'b1;
            decay_cnt    <= '0;
          end else if (decay_cnt != '1) begin
            decay_cnt <= decay_cnt + DW'(1);
          end
        end
        default: begin
          state        <= DECAYED;
          bus_driven   <= 1'b0;
          bus_retained <= 1'b0;
          bus_decayed  <= 1'b1;
        end
      endcase
    end
  end

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_grant_driven  : assert property (@(posedge clk) disable iff (rst) ((|grant) == bus_driven));
  a_status_onehot : assert property (@(posedge clk) disable iff (rst)
                                     $onehot({bus_driven, bus_retained, bus_decayed}));

endmodule
